// File: rtl/alu_pkg.sv
// Shared definitions for the registered MIPS ALU with the iterative
// multiply/divide unit: opcodes, handshake FSM states, overflow helper.
package alu_pkg;

    // 4-bit ALU opcodes. Codes 0-7 are unchanged from the single-cycle ALU.
    localparam logic [3:0] OP_AND   = 4'h0;
    localparam logic [3:0] OP_OR    = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_ANDN  = 4'h4;
    localparam logic [3:0] OP_ORN   = 4'h5;
    localparam logic [3:0] OP_SLT   = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_SLTU  = 4'h8;
    localparam logic [3:0] OP_MULT  = 4'h9;
    localparam logic [3:0] OP_MULTU = 4'hA;
    localparam logic [3:0] OP_DIV   = 4'hB;
    localparam logic [3:0] OP_DIVU  = 4'hC;
    localparam logic [3:0] OP_MFHI  = 4'hD;
    localparam logic [3:0] OP_MFLO  = 4'hE;
    localparam logic [3:0] OP_NOR   = 4'hF;

    // Handshake FSM: IDLE accepts, RUN iterates, FIX applies sign and retires.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Two's-complement add overflow from the sign bits alone: both operands
    // share a sign and the result sign differs. For SUB, pass ~b_msb.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative radix-2 multiply / restoring divide engine. Owns the HI/LO
// architectural registers. A start with a zero divisor writes HI/LO
// immediately; every other start runs WIDTH iterations plus one fixup cycle.
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,    // accepted MULT/MULTU/DIV/DIVU
    input  logic             div_i,      // 1: divide, 0: multiply
    input  logic             signed_i,   // 1: MULT/DIV, 0: MULTU/DIVU
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,     // final iteration happens this cycle
    output logic [WIDTH-1:0] lo_fix_o,   // sign-corrected LO, valid in fixup
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic             run_q, run_d;
    logic             fix_q, fix_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             neg_q, neg_d;        // negate product / quotient
    logic             rem_neg_q, rem_neg_d; // remainder takes dividend sign
    logic [WIDTH-1:0] mcand_q, mcand_d;    // |multiplicand| or |divisor|
    logic [WIDTH-1:0] acc_q, acc_d;        // high product half / remainder
    logic [WIDTH-1:0] lsw_q, lsw_d;        // multiplier-low half / quotient
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   hi_fix;

    // Operand magnitudes; MIN_INT maps to its own unsigned magnitude.
    assign a_neg = signed_i & a_i[WIDTH-1];
    assign b_neg = signed_i & b_i[WIDTH-1];
    assign a_mag = a_neg ? (~a_i + 1'b1) : a_i;
    assign b_mag = b_neg ? (~b_i + 1'b1) : b_i;

    // One shift-add step: add multiplicand when the multiplier LSB is set.
    assign mul_sum   = {1'b0, acc_q} + (lsw_q[0] ? {1'b0, mcand_q} : '0);
    // One restoring-divide step: bit WIDTH of the difference is the borrow.
    assign div_shift = {acc_q, lsw_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mcand_q};

    assign prod     = {acc_q, lsw_q};
    assign prod_neg = ~prod + 1'b1;

    // Sign correction applied in the fixup cycle.
    always_comb begin
        lo_fix_o = '0;
        hi_fix   = '0;
        if (div_q) begin
            lo_fix_o = neg_q     ? (~lsw_q + 1'b1) : lsw_q;
            hi_fix   = rem_neg_q ? (~acc_q + 1'b1) : acc_q;
        end else begin
            lo_fix_o = neg_q ? prod_neg[WIDTH-1:0]       : prod[WIDTH-1:0];
            hi_fix   = neg_q ? prod_neg[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
        end
    end

    assign last_o = run_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

    // Next-state for loading, iterating and retiring an operation.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        run_d     = run_q;
        fix_d     = fix_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        lsw_d     = lsw_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        if (start_i) begin
            if (div_i && (b_i == '0)) begin
                hi_d = a_i;
                lo_d = '1;
            end else begin
                run_d     = 1'b1;
                cnt_d     = '0;
                div_d     = div_i;
                neg_d     = a_neg ^ b_neg;
                rem_neg_d = a_neg;
                mcand_d   = b_mag;
                acc_d     = '0;
                lsw_d     = a_mag;
            end
        end else if (run_q) begin
            cnt_d = cnt_q + 1'b1;
            if (div_q) begin
                if (!div_diff[WIDTH]) begin
                    acc_d = div_diff[WIDTH-1:0];
                    lsw_d = {lsw_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = div_shift[WIDTH-1:0];
                    lsw_d = {lsw_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = mul_sum[WIDTH:1];
                lsw_d = {mul_sum[0], lsw_q[WIDTH-1:1]};
            end
            if (last_o) begin
                run_d = 1'b0;
                fix_d = 1'b1;
            end
        end else if (fix_q) begin
            fix_d = 1'b0;
            hi_d  = hi_fix;
            lo_d  = lo_fix_o;
        end
    end

    // Engine state registers; reset aborts any operation and clears HI/LO.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses <= so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            run_q     <= 1'b0;
            fix_q     <= 1'b0;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            mcand_q   <= '0;
            acc_q     <= '0;
            lsw_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            run_q     <= run_d;
            fix_q     <= fix_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            lsw_q     <= lsw_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Registered execute-stage ALU with valid/ready handshake. Single-cycle ops
// retire one cycle after acceptance; MULT/MULTU/DIV/DIVU hand off to
// muldiv_seq and hold in_ready low until the result is written to HI/LO.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] OP_A,
    input  logic [WIDTH-1:0] OP_B,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Overflow,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             is_md;      // handled by the multiply/divide engine
    logic             is_long;    // needs the multi-cycle RUN/FIX path
    logic             md_div;
    logic             md_signed;
    logic             md_start;
    logic             md_last;
    logic [WIDTH-1:0] md_lo_fix;
    logic [WIDTH-1:0] hi, lo;

    assign sum  = OP_A + OP_B;
    assign diff = OP_A - OP_B;

    assign md_div    = (ALUControl == OP_DIV)  || (ALUControl == OP_DIVU);
    assign md_signed = (ALUControl == OP_MULT) || (ALUControl == OP_DIV);
    assign is_md     = md_div || (ALUControl == OP_MULT) || (ALUControl == OP_MULTU);
    assign is_long   = is_md && !(md_div && (OP_B == '0));
    assign md_start  = in_valid && in_ready && is_md;

    // Single-cycle result and overflow for the current opcode.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (ALUControl)
            OP_AND:  alu_res = OP_A & OP_B;
            OP_OR:   alu_res = OP_A | OP_B;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = signed_ovf(OP_A[WIDTH-1], OP_B[WIDTH-1], sum[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = signed_ovf(OP_A[WIDTH-1], ~OP_B[WIDTH-1], diff[WIDTH-1]);
            end
            OP_ANDN: alu_res = OP_A & ~OP_B;
            OP_ORN:  alu_res = OP_A | ~OP_B;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(OP_A) < $signed(OP_B))};
            OP_XOR:  alu_res = OP_A ^ OP_B;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (OP_A < OP_B)};
            OP_DIV, OP_DIVU: alu_res = '1;   // only reaches the output on /0
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            OP_NOR:  alu_res = ~(OP_A | OP_B);
            default: alu_res = '0;           // MULT/MULTU never retire here
        endcase
    end

    // Handshake FSM and output-register next state.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_long) begin
                        state_d = RUN;
                    end else begin
                        result_d    = alu_res;
                        ovf_d       = alu_ovf;
                        out_valid_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (md_last) state_d = FIX;
            end
            FIX: begin
                state_d     = IDLE;
                result_d    = md_lo_fix;
                ovf_d       = 1'b0;
                out_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    muldiv_seq #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv_seq (
        .clk      (clk),
        .rst      (rst),
        .start_i  (md_start),
        .div_i    (md_div),
        .signed_i (md_signed),
        .a_i      (OP_A),
        .b_i      (OP_B),
        .last_o   (md_last),
        .lo_fix_o (md_lo_fix),
        .hi_o     (hi),
        .lo_o     (lo)
    );

    assign in_ready  = (state_q == IDLE);
    assign busy      = ~in_ready;
    assign out_valid = out_valid_q;
    assign ALUResult = result_q;
    assign Overflow  = ovf_q;
    assign Zero      = (result_q == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH = 32): directed cases from the
// datapath's corner rules plus randomized ops against an arithmetic model.
module tb_alu_muldiv;
    import alu_pkg::*;

    localparam int W = 32;
    localparam int LONG_LAT = W + 2;   // samples from accept edge to out_valid
    localparam longint S_MAX = 64'sh0000_0000_7FFF_FFFF;
    localparam longint S_MIN = -64'sh0000_0000_8000_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a, op_b;
    logic [3:0]   alu_control;
    logic         out_valid;
    logic [W-1:0] alu_result;
    logic         zero;
    logic         overflow;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] hi_m, lo_m;   // reference HI/LO

    alu_muldiv #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .OP_A       (op_a),
        .OP_B       (op_b),
        .ALUControl (alu_control),
        .out_valid  (out_valid),
        .ALUResult  (alu_result),
        .Zero       (zero),
        .Overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: plain integer arithmetic on the operation's meaning.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] res,
                                  output logic ovf, output int lat);
        longint sa, sb, s, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        res = '0; ovf = 1'b0; lat = 1;
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_ADD:  begin s = sa + sb; p = s; res = p[31:0]; ovf = (s > S_MAX) || (s < S_MIN); end
            OP_SUB:  begin s = sa - sb; p = s; res = p[31:0]; ovf = (s > S_MAX) || (s < S_MIN); end
            OP_ANDN: res = a & ~b;
            OP_ORN:  res = a | ~b;
            OP_SLT:  res = (sa < sb) ? 32'd1 : 32'd0;
            OP_XOR:  res = a ^ b;
            OP_SLTU: res = (a < b) ? 32'd1 : 32'd0;
            OP_MULT: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; res = lo_m; lat = LONG_LAT; end
            OP_MULTU: begin p = ua * ub; hi_m = p[63:32]; lo_m = p[31:0]; res = lo_m; lat = LONG_LAT; end
            OP_DIV, OP_DIVU: begin
                if (b == 0) begin
                    hi_m = a; lo_m = '1; res = '1;
                end else begin
                    if (op == OP_DIV) begin q = sa / sb; r = sa % sb; end
                    else begin q = longint'(ua / ub); r = longint'(ua % ub); end
                    p = q; lo_m = p[31:0];
                    p = r; hi_m = p[31:0];
                    res = lo_m; lat = LONG_LAT;
                end
            end
            OP_MFHI: res = hi_m;
            OP_MFLO: res = lo_m;
            default: res = ~(a | b);
        endcase
    endfunction

    // Issue one op from IDLE and wait (bounded) for its out_valid pulse.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output logic ovf, output logic z,
                          output int lat, output int rdy_low,
                          output logic [W-1:0] e_res, output logic e_ovf, output int e_lat);
        model(op, a, b, e_res, e_ovf, e_lat);
        in_valid = 1'b1; alu_control = op; op_a = a; op_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1; rdy_low = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) rdy_low++;
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        res = alu_result; ovf = overflow; z = zero;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; alu_control = '0; op_a = '0; op_b = '0;
        hi_m = '0; lo_m = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (alu_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", alu_result); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b expected 1", zero); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add_sub();
        logic [W-1:0] res, er; logic ovf, z, eo; int lat, rl, el;
        run_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, res, ovf, z, lat, rl, er, eo, el);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d expected 1", lat); end
        n_checks++; if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL add_result: got %h expected 80000000", res); end
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL add_overflow: got %b expected 1", ovf); end
        n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL add_zero: got %b expected 0", z); end
        run_op(OP_SUB, 32'd5, 32'd5, res, ovf, z, lat, rl, er, eo, el);
        n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL sub_result: got %h expected 0", res); end
        n_checks++; if (z !== 1'b1) begin n_fail++; $display("FAIL sub_zero: got %b expected 1", z); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL sub_overflow: got %b expected 0", ovf); end
        run_op(OP_SUB, 32'h8000_0000, 32'h1, res, ovf, z, lat, rl, er, eo, el);
        n_checks++; if (ovf !== 1'b1 || res !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL sub_overflow_min: got %b/%h expected 1/7fffffff", ovf, res); end
    endtask

    task automatic test_slt_nor();
        logic [W-1:0] res, er; logic ovf, z, eo; int lat, rl, el;
        run_op(OP_SLT, 32'hFFFF_FFFF, 32'h1, res, ovf, z, lat, rl, er, eo, el);
        n_checks++; if (res !== 32'h1) begin n_fail++; $display("FAIL slt: got %h expected 1", res); end
        run_op(OP_SLTU, 32'hFFFF_FFFF, 32'h1, res, ovf, z, lat, rl, er, eo, el);
        n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL sltu: got %h expected 0", res); end
        run_op(OP_NOR, 32'h0, 32'h0, res, ovf, z, lat, rl, er, eo, el);
        n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL nor: got %h expected ffffffff", res); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [3];
        logic [W-1:0] a, b, er; logic eo; int el;
        logic [W-1:0] exp_r [3];
        logic [W-1:0] got_r [3];
        logic got_v [3];
        ops[0] = OP_XOR; ops[1] = OP_ADD; ops[2] = OP_ORN;
        for (int i = 0; i < 3; i++) begin
            a = $urandom(); b = $urandom();
            model(ops[i], a, b, er, eo, el);
            exp_r[i] = er;
            in_valid = 1'b1; alu_control = ops[i]; op_a = a; op_b = b;
            @(posedge clk); #1;
            got_v[i] = out_valid; got_r[i] = alu_result;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (got_v[i] !== 1'b1 || got_r[i] !== exp_r[i]) begin
                n_fail++; $display("FAIL b2b_op%0d: got valid=%b result=%h expected valid=1 result=%h", i, got_v[i], got_r[i], exp_r[i]);
            end
        end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_mul();
        logic [W-1:0] res, er; logic ovf, z, eo; int lat, rl, el;
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, res, ovf, z, lat, rl, er, eo, el);
        n_checks++; if (rl !== 33) begin n_fail++; $display("FAIL mult_ready_low: got %0d cycles expected 33", rl); end
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL mult_latency: got %0d expected 34", lat); end
        n_checks++; if (res !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_lo: got %h expected fffffff1", res); end
        run_op(OP_MFHI, 32'h0, 32'h0, res, ovf, z, lat, rl, er, eo, el);
        n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", res); end
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, res, ovf, z, lat, rl, er, eo, el);
        n_checks++; if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_lo: got %h expected fffffffe", res); end
        run_op(OP_MFHI, 32'h0, 32'h0, res, ovf, z, lat, rl, er, eo, el);
        n_checks++; if (res !== 32'h1) begin n_fail++; $display("FAIL multu_hi: got %h expected 1", res); end
    endtask

    task automatic test_div();
        logic [W-1:0] res, er; logic ovf, z, eo; int lat, rl, el;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, res, ovf, z, lat, rl, er, eo, el);
        n_checks++; if (res !== 32'hFFFF_FFFD || lat !== 34) begin n_fail++; $display("FAIL div_lo: got %h lat %0d expected fffffffd lat 34", res, lat); end
        run_op(OP_MFHI, 32'h0, 32'h0, res, ovf, z, lat, rl, er, eo, el);
        n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi: got %h expected ffffffff", res); end
        run_op(OP_DIVU, 32'd7, 32'd0, res, ovf, z, lat, rl, er, eo, el);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL divu0_latency: got %0d expected 1", lat); end
        n_checks++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu0_lo: got %h expected ffffffff", res); end
        run_op(OP_MFHI, 32'h0, 32'h0, res, ovf, z, lat, rl, er, eo, el);
        n_checks++; if (res !== 32'd7) begin n_fail++; $display("FAIL divu0_hi: got %h expected 7", res); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, ovf, z, lat, rl, er, eo, el);
        n_checks++; if (res !== 32'h8000_0000 || ovf !== 1'b0 || lat !== 34) begin
            n_fail++; $display("FAIL div_min_lo: got %h ovf %b lat %0d expected 80000000 ovf 0 lat 34", res, ovf, lat);
        end
        run_op(OP_MFHI, 32'h0, 32'h0, res, ovf, z, lat, rl, er, eo, el);
        n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL div_min_hi: got %h expected 0", res); end
    endtask

    task automatic test_ignore_busy();
        logic [W-1:0] a, b, c, d, mres, ares; logic mo, ao; int ml, al, lat, extra;
        a = $urandom(); b = $urandom(); c = $urandom(); d = $urandom();
        model(OP_MULT, a, b, mres, mo, ml);
        model(OP_ADD, c, d, ares, ao, al);
        in_valid = 1'b1; alu_control = OP_MULT; op_a = a; op_b = b;
        @(posedge clk); #1;
        alu_control = OP_ADD; op_a = c; op_b = d;   // held request while busy
        lat = 1;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        n_checks++; if (lat !== 34 || alu_result !== mres) begin
            n_fail++; $display("FAIL busy_mult: got %h lat %0d expected %h lat 34", alu_result, lat, mres);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || alu_result !== ares || overflow !== ao) begin
            n_fail++; $display("FAIL busy_add: got valid=%b %h ovf %b expected valid=1 %h ovf %b", out_valid, alu_result, overflow, ares, ao);
        end
        extra = 0;
        for (int i = 0; i < 5; i++) begin @(posedge clk); #1; if (out_valid) extra++; end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL busy_once: got %0d extra pulses expected 0", extra); end
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 4))
            0: v = 32'h8000_0000;
            1: v = 32'h7FFF_FFFF;
            2: begin v = $urandom_range(0, 16); v = v - 32'd8; end
            3: v = '0;
            default: v = $urandom();
        endcase
        return v;
    endfunction

    task automatic test_random();
        logic [W-1:0] a, b, res, er; logic ovf, z, eo; logic [3:0] op; int lat, rl, el;
        for (int i = 0; i < 120; i++) begin
            op = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 1) == 0) ? pick() : $urandom();
            b = ($urandom_range(0, 1) == 0) ? pick() : $urandom();
            run_op(op, a, b, res, ovf, z, lat, rl, er, eo, el);
            n_checks++; if (lat !== el || res !== er || ovf !== eo || z !== (er == '0)) begin
                n_fail++;
                $display("FAIL rand%0d op=%h a=%h b=%h: got %h ovf %b zero %b lat %0d expected %h ovf %b zero %b lat %0d",
                         i, op, a, b, res, ovf, z, lat, er, eo, (er == '0), el);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] res, er; logic ovf, z, eo; int lat, rl, el, pulses;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, res, ovf, z, lat, rl, er, eo, el);
        in_valid = 1'b1; alu_control = OP_DIV; op_a = 32'd1000; op_b = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got ready=%b busy=%b expected 1/0", in_ready, busy); end
        n_checks++; if (out_valid !== 1'b0 || alu_result !== 32'h0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL abort_outputs: got valid=%b %h ovf %b expected 0 00000000 0", out_valid, alu_result, overflow);
        end
        #1 rst = 1'b0;
        hi_m = '0; lo_m = '0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (out_valid) pulses++; end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d pulses expected 0", pulses); end
        run_op(OP_MFHI, 32'h0, 32'h0, res, ovf, z, lat, rl, er, eo, el);
        n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL abort_hi: got %h expected 0", res); end
        run_op(OP_MFLO, 32'h0, 32'h0, res, ovf, z, lat, rl, er, eo, el);
        n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL abort_lo: got %h expected 0", res); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_slt_nor();
        test_back_to_back();
        test_mul();
        test_div();
        test_ignore_busy();
        test_random();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised, registered successor of the single-cycle ALU for the MIPS datapath.
- Keeps the existing 8 logic/arithmetic ops and their encodings (zero-extended to 4 bits).
- Adds unsigned compare, NOR, signed-add overflow flag, and iterative MULT/MULTU/DIV/DIVU writing internal HI/LO registers, plus MFHI/MFLO readback.
- Sits in the execute stage and stalls the core through a valid/ready handshake while a multi-cycle op is in flight.

Parameters:
- WIDTH, 32, operand/result/HI/LO width (must be ≥ 4).
- CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; high in IDLE only
- OP_A  in  WIDTH  signed operand A
- OP_B  in  WIDTH  signed operand B
- ALUControl  in  4  opcode: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 AND-NOT-B, 5 OR-NOT-B, 6 SLT signed, 7 XOR, 8 SLTU, 9 MULT, A MULTU, B DIV, C DIVU, D MFHI, E MFLO, F NOR
- out_valid  out  1  one-cycle pulse, result valid
- ALUResult  out  WIDTH  registered result
- Zero  out  1  (ALUResult == 0), combinational from the result register
- Overflow  out  1  registered signed overflow; ADD/SUB only, else 0
- busy  out  1  multi-cycle op in progress (= ~in_ready)

Behaviour:
- Reset values (async, any state): state IDLE, in_ready 1, busy 0, out_valid 0, ALUResult 0, Overflow 0, HI 0, LO 0, counter 0. Zero therefore reads 1.
- Accept: a request is accepted on a rising edge where in_valid && in_ready. in_valid while in_ready=0 is ignored; there is no queueing.
- Single-cycle ops (0–8, D, E, F):
  - Result registered at the accept edge E.
  - out_valid is high for the cycle after E.
  - Latency is 1. Back-to-back issue every cycle is allowed.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - Overflow = operand signs agree (B inverted for SUB) and result sign differs.
  - SLT/SLTU produce a zero-extended 0/1.
- MFHI/MFLO return the current HI/LO.
- MULT/MULTU/DIV/DIVU:
  - IDLE→RUN at E; operands are latched as magnitudes (signed ops) with the result sign recorded.
  - RUN lasts exactly WIDTH cycles, radix-2: shift-add for multiply, restoring divide.
  - RUN→FIX applies the sign correction and writes HI/LO.
  - FIX→IDLE, with out_valid pulsed and ALUResult = LO.
  - out_valid is high in the cycle after edge E+WIDTH+1; in_ready is high in that same cycle.
- MULT/MULTU result: {HI,LO} = full 2·WIDTH product.
- DIV/DIVU result: LO = quotient truncated toward zero, HI = remainder carrying the sign of the dividend.
- Divide by zero (OP_B == 0, DIV or DIVU):
  - Skips RUN: HI = OP_A, LO = all ones.
  - Completes with latency 1, like a single-cycle op.
- DIV of MIN_INT by −1: LO = MIN_INT, HI = 0, normal multi-cycle latency, Overflow stays 0.
- During RUN/FIX, ALUResult and Overflow hold their last values; HI/LO hold until FIX.
- Reset mid-operation aborts immediately: outputs return to reset values and HI/LO are cleared; the aborted op never produces out_valid.

Decomposition:
- Package alu_pkg holds:
  - 4-bit opcode localparams (OP_AND … OP_NOR);
  - the state enum (IDLE, RUN, FIX);
  - a helper function for signed overflow detection.
- Sub-module muldiv_seq holds the iterative engine: counter, partial-product/remainder registers, sign fixup. It exposes start/done plus HI/LO.
- alu_muldiv keeps the combinational op mux, the handshake FSM and the output registers.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 → next cycle out_valid=1, ALUResult=0x80000000, Overflow=1, Zero=0. SUB 5−5 → ALUResult 0, Zero=1, Overflow=0.
- SLT 0xFFFFFFFF vs 0x00000001 → 1; SLTU with the same operands → 0; NOR 0 vs 0 → 0xFFFFFFFF; back-to-back single-cycle ops on 3 consecutive cycles → 3 consecutive out_valid pulses.
- MULT −3 × 5 → in_ready low for 33 cycles, out_valid in cycle 34, ALUResult=LO=0xFFFFFFF1; following MFHI → 0xFFFFFFFF. MULTU 0xFFFFFFFF × 2 → HI=1, LO=0xFFFFFFFE.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 0 → one-cycle latency, LO=0xFFFFFFFF, HI=7. DIV 0x80000000 / −1 → LO=0x80000000, HI=0.
- in_valid held with an ADD during a MULT → ignored until in_ready returns, then accepted exactly once.
- rst pulsed asynchronously 10 cycles into a DIV → out_valid stays 0, in_ready=1 immediately, subsequent MFHI/MFLO → 0.
